// File: rtl/conv_window_collector.sv
`timescale 1ns/1ps
// Collects interior convolution results from a raster-ordered stream, drops border windows,
// and buffers survivors in a small FIFO with row/frame tags for the next stage.
module conv_window_collector #(
    parameter int IMG_Width  = 7,
    parameter int IMG_Height = 7,
    parameter int K          = 5,
    parameter int Datawidth  = 8,
    parameter int FIFO_Depth = 4
) (
    input  logic                                  CLK,
    input  logic                                  CLR,
    input  logic [Datawidth-1:0]                  Data_IN,
    input  logic                                  Valid_IN,
    output logic [Datawidth-1:0]                  Data_OUT,
    output logic                                  Valid_OUT,
    input  logic                                  Ready_IN,
    output logic                                  Row_Last,
    output logic                                  Last,
    output logic                                  Frame_Done,
    output logic                                  Overflow,
    output logic [$clog2(FIFO_Depth+1)-1:0]       Count,
    output logic [1:0]                            state_dbg
);

    localparam int COL_W = $clog2(IMG_Width + 1);
    localparam int ROW_W = $clog2(IMG_Height + 1);
    localparam int AW    = $clog2(FIFO_Depth);
    localparam int CNT_W = $clog2(FIFO_Depth + 1);

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_Width - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_Height - 1);
    localparam logic [COL_W-1:0] COL_KEEP = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_KEEP = ROW_W'(K - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_Depth);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic [Datawidth-1:0] data_mem [FIFO_Depth];
    logic                 rl_mem   [FIFO_Depth];
    logic                 l_mem    [FIFO_Depth];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 overflow_q;

    logic at_col_end, at_frame_end, keep;
    logic accept, push, pop, drop, frame_done;

    assign at_col_end   = (col_q == COL_MAX);
    assign at_frame_end = at_col_end && (row_q == ROW_MAX);
    assign keep         = (col_q >= COL_KEEP) && (row_q >= ROW_KEEP);

    // Handshake: a word leaves the FIFO on any edge where Valid_OUT && Ready_IN;
    // Valid_OUT never depends on Ready_IN, and a full FIFO still accepts when it pops.
    assign Valid_OUT = (count_q != '0);
    assign pop       = Valid_OUT && Ready_IN;
    assign push      = accept && keep && ((count_q != DEPTH_C) || pop);
    assign drop      = (accept && keep && !push) || ((state_q == FLUSH) && Valid_IN);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                accept = Valid_IN;
                if (Valid_IN) begin
                    state_d = at_frame_end ? FLUSH : COLLECT;
                end
            end
            COLLECT: begin
                accept = Valid_IN;
                if (Valid_IN && at_frame_end) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Stay closed to new input until the last tagged word has left.
                if (count_q == '0) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (at_col_end) begin
                col_q <= '0;
                row_q <= at_frame_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < FIFO_Depth; i++) begin
                data_mem[i] <= '0;
                rl_mem[i]   <= 1'b0;
                l_mem[i]    <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr_q] <= Data_IN;
                rl_mem[wr_ptr_q]   <= at_col_end;
                l_mem[wr_ptr_q]    <= at_frame_end;
                wr_ptr_q           <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // Tags of a stale slot are masked so they only mean something alongside Valid_OUT.
    assign Data_OUT   = data_mem[rd_ptr_q];
    assign Row_Last   = Valid_OUT && rl_mem[rd_ptr_q];
    assign Last       = Valid_OUT && l_mem[rd_ptr_q];
    assign Frame_Done = frame_done;
    assign Overflow   = overflow_q;
    assign Count      = count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_conv_window_collector.sv
`timescale 1ns/1ps
// Directed bench for conv_window_collector on the default 7x7 image with a 5x5 kernel.
module tb_conv_window_collector;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          CLR;
    logic [DW-1:0] Data_IN;
    logic          Valid_IN;
    logic [DW-1:0] Data_OUT;
    logic          Valid_OUT;
    logic          Ready_IN;
    logic          Row_Last;
    logic          Last;
    logic          Frame_Done;
    logic          Overflow;
    logic [2:0]    Count;
    logic [1:0]    state_dbg;

    conv_window_collector dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .Data_IN   (Data_IN),
        .Valid_IN  (Valid_IN),
        .Data_OUT  (Data_OUT),
        .Valid_OUT (Valid_OUT),
        .Ready_IN  (Ready_IN),
        .Row_Last  (Row_Last),
        .Last      (Last),
        .Frame_Done(Frame_Done),
        .Overflow  (Overflow),
        .Count     (Count),
        .state_dbg (state_dbg)
    );

    // clock
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int fd_cyc = -1;
    int last_pop_cyc = -2;

    // observed pops as {Row_Last, Last, Data_OUT}
    logic [DW+1:0] obs_q[$];

    // expected interior results in raster order, {RL, L, data}
    logic [DW+1:0] exp_q [9] = '{
        {2'b00, 8'd32}, {2'b00, 8'd33}, {2'b10, 8'd34},
        {2'b00, 8'd39}, {2'b00, 8'd40}, {2'b10, 8'd41},
        {2'b00, 8'd46}, {2'b00, 8'd47}, {2'b11, 8'd48}
    };

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (Valid_OUT && Ready_IN) begin
            obs_q.push_back({Row_Last, Last, Data_OUT});
            if (Last) last_pop_cyc = cyc;
        end
        if (Frame_Done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        obs_q.delete();
        fd_cnt       = 0;
        fd_cyc       = -1;
        last_pop_cyc = -2;
    endtask

    task automatic do_reset();
        CLR      = 1'b0;
        Valid_IN = 1'b0;
        Ready_IN = 1'b0;
        Data_IN  = '0;
        repeat (2) step();
        CLR = 1'b1;
        step();
        clear_mon();
    endtask

    task automatic send(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            Valid_IN = 1'b1;
            Data_IN  = i[7:0];
            step();
            Valid_IN = 1'b0;
            repeat (gap) step();
        end
        Valid_IN = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 40 && fd_cnt == 0; k++) step();
        checks++;
        if (fd_cnt == 0) begin
            errors++;
            $display("FAIL %s frame_done_timeout got=0 exp=1", name);
        end
        repeat (3) step();
    endtask

    task automatic check_stream(input string name, input int n);
        checks++;
        if (obs_q.size() != n) begin
            errors++;
            $display("FAIL %s out_count got=%0d exp=%0d", name, obs_q.size(), n);
        end
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word%0d got={rl,l,d}=%b/%0d exp=%b/%0d", name, i,
                         obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_reset();
        CLR = 1'b0; Valid_IN = 1'b0; Ready_IN = 1'b0; Data_IN = '0;
        step();
        checks++;
        if ({Valid_OUT, Row_Last, Last, Frame_Done, Overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {Valid_OUT, Row_Last, Last, Frame_Done, Overflow});
        end
        checks++;
        if (Count !== 3'd0 || Data_OUT !== 8'd0) begin
            errors++;
            $display("FAIL reset_count_data got=%0d/%0d exp=0/0", Count, Data_OUT);
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=0", state_dbg);
        end
        CLR = 1'b1;
        step();
        clear_mon();
    endtask

    task automatic test_continuous();
        Ready_IN = 1'b1;
        send(0, 48, 0);
        wait_done("continuous");
        check_stream("continuous", 9);
        checks++;
        if (fd_cnt !== 1 || fd_cyc !== last_pop_cyc + 1) begin
            errors++;
            $display("FAIL continuous_frame_done got=cnt%0d/cyc%0d exp=cnt1/cyc%0d",
                     fd_cnt, fd_cyc, last_pop_cyc + 1);
        end
        checks++;
        if (Overflow !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL continuous_ovf_state got=%b/%0d exp=0/0", Overflow, state_dbg);
        end
    endtask

    task automatic test_gapped();
        do_reset();
        Ready_IN = 1'b1;
        send(0, 48, 2);
        wait_done("gapped");
        check_stream("gapped", 9);
        checks++;
        if (fd_cnt !== 1 || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL gapped_done_ovf got=%0d/%b exp=1/0", fd_cnt, Overflow);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        Ready_IN = 1'b0;
        send(0, 39, 0);
        checks++;
        if (Count !== 3'd4 || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_before40 got=count%0d/ovf%b exp=count4/ovf0", Count, Overflow);
        end
        send(40, 40, 0);
        checks++;
        if (Overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_ovf_at40 got=%b exp=1", Overflow);
        end
        send(41, 48, 0);
        repeat (5) step();
        checks++;
        if (Count !== 3'd4 || state_dbg !== 2'd2 || Data_OUT !== 8'd32) begin
            errors++;
            $display("FAIL bp_hold got=count%0d/state%0d/head%0d exp=count4/state2/head32",
                     Count, state_dbg, Data_OUT);
        end
        checks++;
        if (obs_q.size() != 0 || fd_cnt != 0) begin
            errors++;
            $display("FAIL bp_no_output got=%0d/%0d exp=0/0", obs_q.size(), fd_cnt);
        end
        Ready_IN = 1'b1;
        wait_done("backpressure");
        check_stream("backpressure", 4);
        checks++;
        if (fd_cnt !== 1 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL bp_done got=%0d/state%0d exp=1/0", fd_cnt, state_dbg);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        Ready_IN = 1'b0;
        send(0, 39, 0);
        Ready_IN = 1'b1;
        send(40, 40, 0);
        checks++;
        if (Count !== 3'd4 || Overflow !== 1'b0 || Data_OUT !== 8'd33) begin
            errors++;
            $display("FAIL fullpop got=count%0d/ovf%b/head%0d exp=count4/ovf0/head33",
                     Count, Overflow, Data_OUT);
        end
        send(41, 48, 0);
        wait_done("full_pop");
        check_stream("full_pop", 9);
        checks++;
        if (Overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_ovf_end got=%b exp=0", Overflow);
        end
    endtask

    task automatic test_flush_valid();
        do_reset();
        Ready_IN = 1'b1;
        send(0, 48, 0);
        Ready_IN = 1'b0;
        Valid_IN = 1'b1;
        Data_IN  = 8'd77;
        step();
        Valid_IN = 1'b0;
        checks++;
        if (Overflow !== 1'b1 || Count !== 3'd1 || Data_OUT !== 8'd48 || state_dbg !== 2'd2) begin
            errors++;
            $display("FAIL flush_valid got=ovf%b/count%0d/head%0d/state%0d exp=ovf1/count1/head48/state2",
                     Overflow, Count, Data_OUT, state_dbg);
        end
        Ready_IN = 1'b1;
        wait_done("flush_valid");
        check_stream("flush_valid", 9);
        clear_mon();
        send(0, 48, 0);
        wait_done("flush_next");
        check_stream("flush_next", 9);
    endtask

    task automatic test_clr_midframe();
        do_reset();
        Ready_IN = 1'b0;
        send(0, 36, 0);
        checks++;
        if (Count !== 3'd3) begin
            errors++;
            $display("FAIL clr_pre_count got=%0d exp=3", Count);
        end
        @(posedge CLK);
        #3 CLR = 1'b0;
        #1;
        checks++;
        if ({Valid_OUT, Row_Last, Last, Frame_Done, Overflow} !== 5'b0 || Count !== 3'd0 ||
            Data_OUT !== 8'd0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL clr_async got=flags%b/count%0d/data%0d/state%0d exp=00000/0/0/0",
                     {Valid_OUT, Row_Last, Last, Frame_Done, Overflow}, Count, Data_OUT, state_dbg);
        end
        step();
        CLR = 1'b1;
        step();
        clear_mon();
        Ready_IN = 1'b1;
        send(0, 48, 0);
        wait_done("clr_frame");
        check_stream("clr_frame", 9);
        checks++;
        if (Overflow !== 1'b0 || fd_cnt !== 1) begin
            errors++;
            $display("FAIL clr_frame_end got=ovf%b/fd%0d exp=ovf0/fd1", Overflow, fd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_backpressure();
        test_full_pop();
        test_flush_valid();
        test_clr_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
